// File: rtl/mem_1rw_sync_soft.sv
// Soft single-port synchronous RAM with a registered read port.
// Used whenever no hardened 1RW macro matches the requested width/depth.
module mem_1rw_sync_soft #(
    parameter int width_p           = 8,
    parameter int els_p             = 16,
    parameter int addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
    parameter bit substitute_1r1w_p = 1'b1,
    parameter bit latch_last_read_p = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];
    logic [width_p-1:0] rd_word;
    logic [width_p-1:0] data_q;
    logic               in_range;
    logic               wr_en;
    logic               rd_en;

    // Addresses past els_p only exist for non-power-of-two depths.
    assign in_range = 32'(addr_i) < 32'(els_p);
    assign wr_en    = reset_i & v_i & w_i & in_range;
    assign rd_en    = v_i & ~w_i;
    assign rd_word  = in_range ? mem[addr_i] : '0;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[addr_i] <= data_i;
        end
    end

    // Substitute mode samples the array every edge; non-blocking update
    // means a same-cycle write shows the pre-write word.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_q <= '0;
        end else if (substitute_1r1w_p) begin
            data_q <= rd_word;
        end else if (rd_en) begin
            data_q <= rd_word;
        end else if (!latch_last_read_p) begin
            data_q <= '0;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_mem_1rw_sync_soft.sv
// Directed and random checks of mem_1rw_sync_soft in all three output modes
// plus a non-power-of-two depth instance, all sharing one stimulus stream.
module tb_mem_1rw_sync_soft;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] data_i;
    logic [3:0] addr_i;
    logic       v_i;
    logic       w_i;
    logic [7:0] o_sub, o_lat, o_zro, o_b;

    logic [7:0] m16 [16];
    logic [7:0] m12 [12];
    logic [7:0] e_sub, e_lat, e_zro, e_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    mem_1rw_sync_soft #(.width_p(8), .els_p(16), .substitute_1r1w_p(1'b1), .latch_last_read_p(1'b1)) dut_sub (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .addr_i(addr_i), .v_i(v_i), .w_i(w_i), .data_o(o_sub));
    mem_1rw_sync_soft #(.width_p(8), .els_p(16), .substitute_1r1w_p(1'b0), .latch_last_read_p(1'b1)) dut_lat (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .addr_i(addr_i), .v_i(v_i), .w_i(w_i), .data_o(o_lat));
    mem_1rw_sync_soft #(.width_p(8), .els_p(16), .substitute_1r1w_p(1'b0), .latch_last_read_p(1'b0)) dut_zro (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .addr_i(addr_i), .v_i(v_i), .w_i(w_i), .data_o(o_zro));
    mem_1rw_sync_soft #(.width_p(8), .els_p(12), .substitute_1r1w_p(1'b1), .latch_last_read_p(1'b1)) dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .addr_i(addr_i), .v_i(v_i), .w_i(w_i), .data_o(o_b));

    // Drive one access, update the reference model, advance one edge.
    task automatic step(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r16, r12;
        v_i = v; w_i = w; addr_i = a; data_i = d;
        r16 = m16[a];
        r12 = (a < 4'd12) ? m12[a] : 8'h00;
        e_sub = r16;
        e_b   = r12;
        if (v && !w) begin
            e_lat = r16;
            e_zro = r16;
        end else begin
            e_zro = 8'h00;
        end
        if (v && w) begin
            m16[a] = d;
            if (a < 4'd12) m12[a] = d;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_fill;
        for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 4'(a), 8'(a * 17));
        step(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 4'd3, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h33333333) begin
            miscompares++;
            $display("FAIL reset_pre_read: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h33333333);
        end
        #2 reset_i = 1'b0;
        #1;
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async_clear: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h0);
        end
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd3; data_i = 8'hEE;
        @(posedge clk_i);
        #1;
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold_zero: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h0);
        end
        reset_i = 1'b1;
        e_sub = 8'h00; e_lat = 8'h00; e_zro = 8'h00; e_b = 8'h00;
        step(1'b1, 1'b0, 4'd3, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h33333333) begin
            miscompares++;
            $display("FAIL reset_write_blocked: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h33333333);
        end
    endtask

    task automatic test_write_read;
        step(1'b1, 1'b1, 4'd3, 8'hA5);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h33330033) begin
            miscompares++;
            $display("FAIL write3_old_value: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h33330033);
        end
        step(1'b1, 1'b1, 4'd15, 8'h5A);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'hFF330000) begin
            miscompares++;
            $display("FAIL write15_old_value: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'hFF330000);
        end
        step(1'b1, 1'b0, 4'd3, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL read3: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'hA5A5A5A5);
        end
        step(1'b1, 1'b0, 4'd15, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h5A5A5A00) begin
            miscompares++;
            $display("FAIL read15: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h5A5A5A00);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b1, 4'd7, 8'h11);
        step(1'b1, 1'b0, 4'd7, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h11111111) begin
            miscompares++;
            $display("FAIL raw_back_to_back: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h11111111);
        end
    endtask

    task automatic test_hold;
        step(1'b1, 1'b0, 4'd3, 8'h00);
        step(1'b0, 1'b0, 4'd15, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h5AA50000) begin
            miscompares++;
            $display("FAIL hold_idle: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h5AA50000);
        end
        step(1'b1, 1'b1, 4'd15, 8'h77);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h5AA50000) begin
            miscompares++;
            $display("FAIL hold_write: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h5AA50000);
        end
        step(1'b1, 1'b0, 4'd15, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h77777700) begin
            miscompares++;
            $display("FAIL read_after_hold: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h77777700);
        end
    endtask

    task automatic test_boundary;
        step(1'b1, 1'b1, 4'd13, 8'hFF);
        step(1'b1, 1'b0, 4'd13, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'hFFFFFF00) begin
            miscompares++;
            $display("FAIL oob_read13: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'hFFFFFF00);
        end
        step(1'b1, 1'b1, 4'd11, 8'h3C);
        step(1'b1, 1'b0, 4'd11, 8'h00);
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h3C3C3C3C) begin
            miscompares++;
            $display("FAIL last_word_read11: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h3C3C3C3C);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(99) == 0) begin
                reset_i = 1'b0;
                #1;
                vectors++;
                if ({o_sub, o_lat, o_zro, o_b} !== 32'h0) begin
                    miscompares++;
                    $display("FAIL rand_reset_async cycle %0d: got %h expected %h", i, {o_sub, o_lat, o_zro, o_b}, 32'h0);
                end
                v_i = 1'($urandom); w_i = 1'($urandom);
                addr_i = 4'($urandom); data_i = 8'($urandom);
                @(posedge clk_i);
                #1;
                reset_i = 1'b1;
                e_sub = 8'h00; e_lat = 8'h00; e_zro = 8'h00; e_b = 8'h00;
            end else begin
                step(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
                vectors++;
                if ({o_sub, o_lat, o_zro, o_b} !== {e_sub, e_lat, e_zro, e_b}) begin
                    miscompares++;
                    $display("FAIL rand_access cycle %0d: got %h expected %h", i, {o_sub, o_lat, o_zro, o_b}, {e_sub, e_lat, e_zro, e_b});
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) m16[a] = 8'h00;
        for (int a = 0; a < 12; a++) m12[a] = 8'h00;
        e_sub = 8'h00; e_lat = 8'h00; e_zro = 8'h00; e_b = 8'h00;
        reset_i = 1'b0;
        v_i = 1'b0; w_i = 1'b0; addr_i = 4'd0; data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if ({o_sub, o_lat, o_zro, o_b} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected %h", {o_sub, o_lat, o_zro, o_b}, 32'h0);
        end
        reset_i = 1'b1;
        test_fill();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_hold();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
